lcd_scan_out: RTL and testbench

Downstream display stage of the LCD controller path. After the controller signals completion, this block reads the processed 8×8 image out of the image buffer (IRB-style synchronous single-port RAM) in raster order. It streams the pixels to the panel interface over a valid/ready handshake and inserts a fixed horizontal blanking gap between rows. A 2-entry skid FIFO absorbs the RAM's one-cycle read latency so that panel back-pressure never drops or duplicates a pixel.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_skid_fifo.sv | 43 ++++
 rtl/lcd_scan_out.sv | 172 +++++++++++++++++
 tb/tb_lcd_scan_out.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and default geometry for the LCD controller path.
// The scan-out stage and the controller both import these constants.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH
    } state_t;

    localparam int LCD_COLS    = 8;
    localparam int LCD_ROWS    = 8;
    localparam int LCD_AW      = 6;
    localparam int LCD_DW      = 8;
    localparam int LCD_H_BLANK = 2;

endpackage

// File: rtl/lcd_skid_fifo.sv
// Two-entry skid FIFO that parks buffer read data
// while the panel applies back-pressure.
module lcd_skid_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem [2];
    logic          wp;
    logic          rp;
    logic [1:0]    cnt;

    // Storage, pointers and occupancy; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rp];
    assign occ  = cnt;

endmodule

// File: rtl/lcd_scan_out.sv
// Reads the finished image out of the buffer in raster order and
// streams it to the panel with per-row horizontal blanking.
module lcd_scan_out
    import lcd_pkg::*;
#(
    parameter int COLS    = LCD_COLS,
    parameter int ROWS    = LCD_ROWS,
    parameter int AW      = LCD_AW,
    parameter int DW      = LCD_DW,
    parameter int H_BLANK = LCD_H_BLANK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          BUF_CEN,
    output logic [AW-1:0] BUF_A,
    input  logic [DW-1:0] BUF_Q,
    output logic [DW-1:0] px_data,
    output logic          px_valid,
    input  logic          px_ready,
    output logic          line_start,
    output logic          frame_end,
    output logic          busy,
    output logic          frame_done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW = (H_BLANK > 0) ? $clog2(H_BLANK + 1) : 1;
    localparam logic [AW-1:0] LAST_A = AW'(COLS * ROWS - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] rd_addr;
    logic          inflight;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [BW-1:0] blank;
    logic          done_q;

    logic [1:0]    occ;
    logic [DW-1:0] head;
    logic          push;
    logic          pop;
    logic          hs;
    logic          issue;
    logic          start_go;
    logic          last_col;
    logic          last_row;
    logic          final_px;
    logic [2:0]    fill;

    lcd_skid_fifo #(
        .DW (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .din   (BUF_Q),
        .pop   (pop),
        .head  (head),
        .occ   (occ)
    );

    // Output side: data returning this cycle is shown directly when the
    // FIFO is empty, which is what gives the two-cycle start latency.
    always_comb begin
        px_valid   = ((occ != 2'd0) || inflight) && (blank == '0);
        px_data    = '0;
        if (px_valid) begin
            px_data = (occ != 2'd0) ? head : BUF_Q;
        end
        hs         = px_valid && px_ready;
        push       = inflight && !((occ == 2'd0) && hs);
        pop        = hs && (occ != 2'd0);
        last_col   = (col == CW'(COLS - 1));
        last_row   = (row == RW'(ROWS - 1));
        final_px   = last_col && last_row;
        line_start = px_valid && (col == '0);
        frame_end  = px_valid && final_px;
        fill       = {1'b0, occ} + {2'b0, inflight} - {2'b0, hs};
    end

    // Next state and read issue; a read only goes out if its data
    // is guaranteed a slot in the FIFO.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        start_go = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !done_q) begin
                    start_go = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                issue = (fill < 3'd2);
                if (issue && (rd_addr == LAST_A)) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (hs && final_px) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and end-of-frame pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (state == FLUSH) && hs && final_px;
        end
    end

    // Read address and in-flight flag; the address parks on the last pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (start_go) begin
                rd_addr <= '0;
            end else if (issue && (rd_addr != LAST_A)) begin
                rd_addr <= rd_addr + AW'(1);
            end
        end
    end

    // Raster position of the pixel at the FIFO head, stepped per handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (start_go) begin
            col <= '0;
            row <= '0;
        end else if (hs) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Horizontal blanking countdown after every row but the last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blank <= '0;
        end else if (hs && last_col && !last_row) begin
            blank <= BW'(H_BLANK);
        end else if (blank != '0) begin
            blank <= blank - BW'(1);
        end
    end

    assign BUF_CEN    = !issue;
    assign BUF_A      = rd_addr;
    assign busy       = (state != IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_scan_out.sv
// Randomised self-checking bench for lcd_scan_out with a
// synchronous buffer model and a raster-order reference.
module tb_lcd_scan_out;

    localparam int COLS    = 8;
    localparam int ROWS    = 8;
    localparam int AW      = 6;
    localparam int DW      = 8;
    localparam int H_BLANK = 2;
    localparam int NPIX    = COLS * ROWS;
    localparam int BUDGET  = 900;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          px_ready = 1'b0;
    logic [DW-1:0] BUF_Q = '0;
    logic          BUF_CEN;
    logic [AW-1:0] BUF_A;
    logic [DW-1:0] px_data;
    logic          px_valid;
    logic          line_start;
    logic          frame_end;
    logic          busy;
    logic          frame_done;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] mem [NPIX];

    logic [DW-1:0] pix_q[$];
    int            hs_cyc[$];
    bit            ls_q[$];
    bit            fe_q[$];
    int            rd_cyc[$];
    logic [AW-1:0] rd_a[$];
    bit            v_log [BUDGET];
    bit            b_log [BUDGET];
    logic [DW-1:0] d_log [BUDGET];
    int            done_cyc;
    int            stable_err;
    int            qual_err;
    int            blank_err;

    lcd_scan_out #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .AW      (AW),
        .DW      (DW),
        .H_BLANK (H_BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .BUF_CEN    (BUF_CEN),
        .BUF_A      (BUF_A),
        .BUF_Q      (BUF_Q),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .line_start (line_start),
        .frame_end  (frame_end),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous single-port buffer; garbage on cycles with no read.
    always @(posedge clk) begin
        if (!BUF_CEN) BUF_Q <= mem[BUF_A];
        else          BUF_Q <= DW'($urandom);
    end

    function automatic logic [19:0] outs();
        return {BUF_CEN, BUF_A, px_data, px_valid,
                line_start, frame_end, busy, frame_done};
    endfunction

    // Reference: pixel k handshakes at T+2+k plus blanking of earlier rows.
    function automatic int exp_hs(input int k);
        return 2 + k + H_BLANK * (k / COLS);
    endfunction

    task automatic load_ramp();
        for (int k = 0; k < NPIX; k++) mem[k] = DW'(k);
    endtask

    task automatic load_random();
        for (int k = 0; k < NPIX; k++) mem[k] = DW'($urandom);
    endtask

    // Runs one frame starting at cycle 0 and logs what the panel sees.
    // mode 0: ready=1, 1: random ready, 2: ready low for cycles 2..11.
    task automatic collect(input int mode, input bit start_on_done,
                           input int extra);
        bit            held;
        logic [DW-1:0] hd;
        int            blank_left;
        pix_q.delete(); hs_cyc.delete(); ls_q.delete(); fe_q.delete();
        rd_cyc.delete(); rd_a.delete();
        done_cyc = -1; stable_err = 0; qual_err = 0; blank_err = 0;
        held = 0; hd = '0; blank_left = 0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == extra) || (start_on_done && frame_done);
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = 1'($urandom_range(0, 1));
                default: px_ready = !(c >= 2 && c < 12);
            endcase
            #1;
            v_log[c] = px_valid;
            b_log[c] = busy;
            d_log[c] = px_data;
            if (!BUF_CEN) begin
                rd_cyc.push_back(c);
                rd_a.push_back(BUF_A);
            end
            if (held && (!px_valid || px_data !== hd)) stable_err++;
            held = px_valid && !px_ready;
            hd = px_data;
            if (!px_valid && (line_start || frame_end)) qual_err++;
            if (blank_left > 0) begin
                if (px_valid) blank_err++;
                blank_left--;
            end
            if (px_valid && px_ready) begin
                pix_q.push_back(px_data);
                hs_cyc.push_back(c);
                ls_q.push_back(line_start);
                fe_q.push_back(frame_end);
                if ((pix_q.size() % COLS) == 0 && pix_q.size() < NPIX)
                    blank_left = H_BLANK;
            end
            if (frame_done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++;
        if (outs() !== 20'h80000) begin
            bad++;
            $display("FAIL reset_outs got=%h want=%h", outs(), 20'h80000);
        end
        start = 1'b1;
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0 || BUF_CEN !== 1'b1) begin
            bad++;
            $display("FAIL reset_start busy=%b cen=%b want 0/1", busy, BUF_CEN);
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_full_ready();
        load_ramp();
        collect(0, 1'b0, -1);
        total++;
        if (pix_q.size() != NPIX) begin
            bad++;
            $display("FAIL full_count got=%0d want=%0d", pix_q.size(), NPIX);
        end
        for (int k = 0; k < pix_q.size() && k < NPIX; k++) begin
            total++;
            if (pix_q[k] !== mem[k] || hs_cyc[k] != exp_hs(k)) begin
                bad++;
                $display("FAIL full_pix k=%0d got=%h@%0d want=%h@%0d",
                         k, pix_q[k], hs_cyc[k], mem[k], exp_hs(k));
            end
        end
        total++;
        if (b_log[0] !== 1'b0 || b_log[1] !== 1'b1) begin
            bad++;
            $display("FAIL full_busy_rise got=%b%b want=01", b_log[0], b_log[1]);
        end
        total++;
        if (rd_cyc.size() != NPIX || rd_cyc[0] != 1) begin
            bad++;
            $display("FAIL full_reads n=%0d first=%0d want=%0d/1",
                     rd_cyc.size(), rd_cyc.size() ? rd_cyc[0] : -1, NPIX);
        end
        for (int i = 0; i < rd_a.size() && i < NPIX; i++) begin
            total++;
            if (rd_a[i] !== AW'(i)) begin
                bad++;
                $display("FAIL full_addr i=%0d got=%0d want=%0d", i, rd_a[i], i);
            end
        end
        total++;
        if (blank_err != 0) begin
            bad++;
            $display("FAIL full_blank got=%0d want=0", blank_err);
        end
        total++;
        if (done_cyc != exp_hs(NPIX - 1) + 1 || b_log[done_cyc < 0 ? 0 : done_cyc] !== 1'b0) begin
            bad++;
            $display("FAIL full_done got=%0d want=%0d", done_cyc, exp_hs(NPIX - 1) + 1);
        end
        @(negedge clk); #1;
        total++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || BUF_CEN !== 1'b1 ||
            BUF_A !== AW'(NPIX - 1)) begin
            bad++;
            $display("FAIL full_idle done=%b busy=%b cen=%b a=%0d want 0/0/1/%0d",
                     frame_done, busy, BUF_CEN, BUF_A, NPIX - 1);
        end
    endtask

    task automatic test_random_ready();
        load_random();
        collect(1, 1'b0, -1);
        total++;
        if (pix_q.size() != NPIX || done_cyc < 0) begin
            bad++;
            $display("FAIL rnd_count got=%0d done=%0d want=%0d", pix_q.size(), done_cyc, NPIX);
        end
        for (int k = 0; k < pix_q.size() && k < NPIX; k++) begin
            total++;
            if (pix_q[k] !== mem[k]) begin
                bad++;
                $display("FAIL rnd_pix k=%0d got=%h want=%h", k, pix_q[k], mem[k]);
            end
        end
        total++;
        if (stable_err != 0 || blank_err != 0 || rd_cyc.size() != NPIX) begin
            bad++;
            $display("FAIL rnd_flow stable=%0d blank=%0d reads=%0d want 0/0/%0d",
                     stable_err, blank_err, rd_cyc.size(), NPIX);
        end
    endtask

    task automatic test_stall();
        int n;
        load_ramp();
        collect(2, 1'b0, -1);
        n = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] >= 1 && rd_cyc[i] <= 11) n++;
        total++;
        if (n != 2 || rd_a[0] !== AW'(0) || rd_a[1] !== AW'(1)) begin
            bad++;
            $display("FAIL stall_reads got=%0d a0=%0d a1=%0d want 2/0/1", n, rd_a[0], rd_a[1]);
        end
        for (int c = 2; c < 12; c++) begin
            total++;
            if (v_log[c] !== 1'b1 || d_log[c] !== mem[0]) begin
                bad++;
                $display("FAIL stall_hold c=%0d got=%b/%h want 1/%h", c, v_log[c], d_log[c], mem[0]);
            end
        end
        total++;
        if (pix_q.size() != NPIX || pix_q[NPIX-1] !== mem[NPIX-1] || stable_err != 0) begin
            bad++;
            $display("FAIL stall_frame got=%0d stable=%0d want=%0d/0", pix_q.size(), stable_err, NPIX);
        end
    endtask

    task automatic test_qualifiers();
        load_random();
        collect(1, 1'b0, -1);
        for (int k = 0; k < ls_q.size() && k < NPIX; k++) begin
            total++;
            if (ls_q[k] != ((k % COLS) == 0) || fe_q[k] != (k == NPIX - 1)) begin
                bad++;
                $display("FAIL qual k=%0d got ls=%b fe=%b want ls=%b fe=%b",
                         k, ls_q[k], fe_q[k], (k % COLS) == 0, k == NPIX - 1);
            end
        end
        total++;
        if (qual_err != 0 || ls_q.size() != NPIX) begin
            bad++;
            $display("FAIL qual_idle got=%0d n=%0d want 0/%0d", qual_err, ls_q.size(), NPIX);
        end
    endtask

    task automatic test_restart();
        load_ramp();
        collect(0, 1'b1, 20);
        total++;
        if (pix_q.size() != NPIX || done_cyc != exp_hs(NPIX - 1) + 1) begin
            bad++;
            $display("FAIL restart_ignore n=%0d done=%0d want %0d/%0d",
                     pix_q.size(), done_cyc, NPIX, exp_hs(NPIX - 1) + 1);
        end
        @(negedge clk);
        start = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_done_cycle busy=%b want 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || BUF_CEN !== 1'b0 || BUF_A !== AW'(0)) begin
            bad++;
            $display("FAIL restart_new busy=%b cen=%b a=%0d want 1/0/0", busy, BUF_CEN, BUF_A);
        end
    endtask

    task automatic test_reset_mid();
        px_ready = 1'b1;
        for (int i = 0; i < 29; i++) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (outs() !== 20'h80000) begin
            bad++;
            $display("FAIL midreset_outs got=%h want=%h", outs(), 20'h80000);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        load_random();
        collect(0, 1'b0, -1);
        total++;
        if (pix_q.size() != NPIX || hs_cyc[0] != 2) begin
            bad++;
            $display("FAIL midreset_count n=%0d first=%0d want %0d/2",
                     pix_q.size(), pix_q.size() ? hs_cyc[0] : -1, NPIX);
        end
        for (int k = 0; k < pix_q.size() && k < NPIX; k++) begin
            total++;
            if (pix_q[k] !== mem[k]) begin
                bad++;
                $display("FAIL midreset_pix k=%0d got=%h want=%h", k, pix_q[k], mem[k]);
            end
        end
    endtask

    initial begin
        load_ramp();
        repeat (2) @(negedge clk);
        test_reset();
        test_full_ready();
        test_random_ready();
        test_stall();
        test_qualifiers();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
